// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: four-channel LED breathing sequencer.
// A tick divider paces a shared brightness level through
// RAMP_UP -> HOLD -> RAMP_DOWN. In sync mode every masked channel
// shows the level. In chase mode one channel at a time shows it,
// and the channel advances after each fade-out.
module pwm_fade_ctrl #(
  parameter int unsigned CLK_DIV    = 100000,
  parameter int unsigned STEP       = 1,
  parameter int unsigned MAX_DUTY   = 255,
  parameter int unsigned HOLD_TICKS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        mode,
  input  logic [3:0]  ch_mask,
  output logic [3:0]  en,
  output logic [31:0] duty_cycle,
  output logic        busy,
  output logic        cycle_done
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [7:0]        STEP8     = 8'(STEP);
  localparam logic [7:0]        MAX8      = 8'(MAX_DUTY);

  typedef enum logic [1:0] {IDLE, RAMP_UP, HOLD, RAMP_DOWN} state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [HOLD_W-1:0] r_hold;
  logic [7:0]        r_level;
  logic              r_stop_pend;
  logic              r_mode;
  logic [3:0]        r_mask;
  logic [1:0]        r_ch;
  logic              r_cycle_done;

  logic              w_tick;
  logic              w_start_ok;
  logic              w_stop_any;
  logic [8:0]        w_up_sum;
  logic [7:0]        w_up_lvl;
  logic [7:0]        w_dn_lvl;
  logic              w_busy;
  logic [3:0]        w_en;

  // Lowest set bit of a channel mask.
  function automatic logic [1:0] f_first_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (m[3-k]) r = 2'(3 - k);
    end
    return r;
  endfunction

  // Next higher set bit after cur, wrapping; falls back to cur itself.
  // Scanned from the farthest offset down so the nearest hit wins.
  function automatic logic [1:0] f_next_ch(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r;
    logic [1:0] idx;
    r = cur;
    for (int unsigned k = 3; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  // Shared combinational helpers: tick, start qualification, next levels.
  always_comb begin
    w_tick     = (r_state != IDLE) && (r_div == DIV_LAST);
    w_start_ok = start && !stop && (ch_mask != '0);
    w_up_sum   = {1'b0, r_level} + {1'b0, STEP8};
    w_up_lvl   = (w_up_sum >= {1'b0, MAX8}) ? MAX8 : w_up_sum[7:0];
    w_dn_lvl   = (r_level > STEP8) ? (r_level - STEP8) : '0;
    w_stop_any = r_stop_pend || stop;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; stop overrides a coincident tick in RAMP_UP/HOLD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_start_ok) w_state_nxt = RAMP_UP;
      RAMP_UP: begin
        if (stop)                            w_state_nxt = RAMP_DOWN;
        else if (w_tick && (w_up_lvl == MAX8)) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (stop)                                 w_state_nxt = RAMP_DOWN;
        else if (w_tick && (r_hold == HOLD_LAST)) w_state_nxt = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (w_tick && (w_dn_lvl == '0)) w_state_nxt = w_stop_any ? IDLE : RAMP_UP;
      end
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Datapath: divider, level, hold counter, stop flag, latched config.
  // Any stop outside IDLE marks the sequence as ending, so a fade forced
  // from RAMP_UP/HOLD also terminates in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div        <= '0;
      r_hold       <= '0;
      r_level      <= '0;
      r_stop_pend  <= 1'b0;
      r_mode       <= 1'b0;
      r_mask       <= '0;
      r_ch         <= '0;
      r_cycle_done <= 1'b0;
    end else begin
      r_cycle_done <= 1'b0;
      if (r_state == IDLE) begin
        r_div <= '0;
        if (w_start_ok) begin
          r_mask      <= ch_mask;
          r_mode      <= mode;
          r_ch        <= f_first_ch(ch_mask);
          r_level     <= '0;
          r_hold      <= '0;
          r_stop_pend <= 1'b0;
        end
      end else begin
        r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        if (stop) r_stop_pend <= 1'b1;
        case (r_state)
          RAMP_UP: begin
            if (!stop && w_tick) begin
              r_level <= w_up_lvl;
              if (w_up_lvl == MAX8) r_hold <= '0;
            end
          end
          HOLD: begin
            if (!stop && w_tick && (r_hold != HOLD_LAST)) r_hold <= r_hold + HOLD_W'(1);
          end
          RAMP_DOWN: begin
            if (w_tick) begin
              r_level <= w_dn_lvl;
              if (w_dn_lvl == '0) begin
                r_cycle_done <= 1'b1;
                if (w_stop_any)  r_stop_pend <= 1'b0;
                else if (r_mode) r_ch <= f_next_ch(r_mask, r_ch);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs decoded from state and datapath registers.
  always_comb begin
    w_busy = (r_state != IDLE);
    w_en   = '0;
    if (w_busy) w_en = r_mode ? (4'b0001 << r_ch) : r_mask;
    busy       = w_busy;
    en         = w_en;
    cycle_done = r_cycle_done;
    duty_cycle = '0;
    for (int unsigned n = 0; n < 4; n++) begin
      if (w_en[n]) duty_cycle[8*n +: 8] = r_level;
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Testbench for pwm_fade_ctrl with CLK_DIV=4, STEP=64, MAX_DUTY=255, HOLD_TICKS=2.
// A phase-based reference model is compared every cycle, alongside
// hand-computed literal expectations at key instants.
module tb_pwm_fade_ctrl;

  localparam int CDIV = 4;
  localparam int STP  = 64;
  localparam int MAXD = 255;
  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  ch_mask = '0;
  logic [3:0]  en;
  logic [31:0] duty_cycle;
  logic        busy;
  logic        cycle_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  bit chk_on   = 1'b0;

  pwm_fade_ctrl #(.CLK_DIV(CDIV), .STEP(STP), .MAX_DUTY(MAXD), .HOLD_TICKS(HOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .ch_mask(ch_mask),
    .en(en), .duty_cycle(duty_cycle), .busy(busy), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 rising, 1 holding, 2 falling
  int m_busy = 0, m_lvl = 0, m_div = 0, m_phase = 0, m_held = 0;
  int m_stop = 0, m_mode = 0, m_mask = 0, m_ch = 0, m_done = 0;

  function automatic int lowest(input int m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int next_ch(input int m, input int c);
    for (int k = 1; k <= 4; k++) if (m[(c + k) % 4]) return (c + k) % 4;
    return c;
  endfunction

  always @(posedge clk) begin
    bit tick;
    m_done = 0;
    if (rst) begin
      m_busy = 0; m_lvl = 0; m_div = 0; m_phase = 0; m_held = 0;
      m_stop = 0; m_mode = 0; m_mask = 0; m_ch = 0;
    end else if (m_busy == 0) begin
      if (start && !stop && ch_mask != 0) begin
        m_busy = 1; m_lvl = 0; m_div = 0; m_phase = 0; m_stop = 0;
        m_mode = int'(mode); m_mask = int'(ch_mask); m_ch = lowest(int'(ch_mask));
      end
    end else begin
      tick  = (m_div == CDIV - 1);
      m_div = tick ? 0 : m_div + 1;
      if (stop) m_stop = 1;
      if (stop && m_phase != 2) begin
        m_phase = 2;
      end else if (tick) begin
        case (m_phase)
          0: begin
            m_lvl = (m_lvl + STP > MAXD) ? MAXD : m_lvl + STP;
            if (m_lvl == MAXD) begin m_phase = 1; m_held = 0; end
          end
          1: begin
            m_held++;
            if (m_held == HOLD) m_phase = 2;
          end
          default: begin
            m_lvl = (m_lvl - STP < 0) ? 0 : m_lvl - STP;
            if (m_lvl == 0) begin
              m_done = 1;
              if (m_stop != 0) begin m_busy = 0; m_stop = 0; end
              else begin
                m_phase = 0;
                if (m_mode != 0) m_ch = next_ch(m_mask, m_ch);
              end
            end
          end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [3:0]  e_en;
    logic [31:0] e_duty;
    if (chk_on) begin
      e_en = '0;
      if (m_busy != 0) e_en = (m_mode != 0) ? 4'(1 << m_ch) : 4'(m_mask);
      e_duty = '0;
      for (int n = 0; n < 4; n++) if (e_en[n]) e_duty[8*n +: 8] = 8'(m_lvl);
      check("model_en", 32'(en), 32'(e_en));
      check("model_duty", duty_cycle, e_duty);
      check("model_busy", 32'(busy), 32'(m_busy));
      check("model_done", 32'(cycle_done), 32'(m_done));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    cyc_cnt++;
  endtask

  task automatic go_to(input int t);
    while (cyc_cnt < t) cyc();
  endtask

  task automatic pulse(input logic s, input logic p, input logic md, input logic [3:0] m);
    start = s; stop = p; mode = md; ch_mask = m;
    cyc();
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    int t0, t1, t2, t3;
    // reset with a competing start: reset must win
    rst = 1'b1; start = 1'b1; ch_mask = 4'b0101;
    cyc();
    start = 1'b0;
    cyc();
    chk_on = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_en", 32'(en), 32'd0);
    check("rst_duty", duty_cycle, 32'd0);
    rst = 1'b0;
    cyc();

    // ignored starts
    pulse(1'b1, 1'b0, 1'b0, 4'b0000);
    check("start_mask0_busy", 32'(busy), 32'd0);
    pulse(1'b1, 1'b1, 1'b0, 4'b0101);
    check("start_stop_busy", 32'(busy), 32'd0);
    check("start_stop_duty", duty_cycle, 32'd0);
    cyc();

    // sync breathing, mask 0101
    pulse(1'b1, 1'b0, 1'b0, 4'b0101);
    t0 = cyc_cnt;
    check("sync_busy", 32'(busy), 32'd1);
    check("sync_en", 32'(en), 32'h5);
    check("sync_duty0", duty_cycle, 32'd0);
    go_to(t0 + 3);  check("sync_pretick", duty_cycle, 32'd0);
    go_to(t0 + 4);  check("sync_t1", duty_cycle, 32'h0040_0040);
    go_to(t0 + 16); check("sync_t4", duty_cycle, 32'h00FF_00FF);
    go_to(t0 + 24); check("sync_hold_end", duty_cycle, 32'h00FF_00FF);
    go_to(t0 + 28); check("sync_d1", duty_cycle, 32'h00BF_00BF);
    go_to(t0 + 39); check("sync_d3", duty_cycle, 32'h003F_003F);
    check("sync_done_early", 32'(cycle_done), 32'd0);
    go_to(t0 + 40); check("sync_done", 32'(cycle_done), 32'd1);
    check("sync_done_duty", duty_cycle, 32'd0);
    go_to(t0 + 41); check("sync_done_pulse", 32'(cycle_done), 32'd0);
    go_to(t0 + 44); check("sync_restart", duty_cycle, 32'h0040_0040);

    // stop during HOLD at 255
    go_to(t0 + 57);
    pulse(1'b0, 1'b1, 1'b0, 4'b0101);
    check("hstop_busy", 32'(busy), 32'd1);
    check("hstop_lvl", duty_cycle, 32'h00FF_00FF);
    go_to(t0 + 60); check("hstop_d1", duty_cycle, 32'h00BF_00BF);
    go_to(t0 + 72); check("hstop_done", 32'(cycle_done), 32'd1);
    check("hstop_idle", 32'(busy), 32'd0);
    check("hstop_en", 32'(en), 32'd0);
    go_to(t0 + 73); check("hstop_after", 32'(cycle_done), 32'd0);
    check("hstop_duty", duty_cycle, 32'd0);
    cyc();

    // chase, mask 1010
    pulse(1'b1, 1'b0, 1'b1, 4'b1010);
    t1 = cyc_cnt;
    check("chase_en0", 32'(en), 32'h2);
    go_to(t1 + 4);  check("chase_t1", duty_cycle, 32'h0000_4000);
    go_to(t1 + 40); check("chase_en1", 32'(en), 32'h8);
    check("chase_done", 32'(cycle_done), 32'd1);
    go_to(t1 + 44); check("chase_t1b", duty_cycle, 32'h4000_0000);
    go_to(t1 + 80); check("chase_wrap", 32'(en), 32'h2);

    // stop during RAMP_DOWN, then a start while busy
    go_to(t1 + 108);
    pulse(1'b0, 1'b1, 1'b1, 4'b1010);
    pulse(1'b1, 1'b0, 1'b0, 4'b1111);
    check("dstop_en", 32'(en), 32'h2);
    check("dstop_lvl", duty_cycle, 32'h0000_BF00);
    go_to(t1 + 112); check("dstop_d", duty_cycle, 32'h0000_7F00);
    go_to(t1 + 120); check("dstop_done", 32'(cycle_done), 32'd1);
    check("dstop_idle", 32'(busy), 32'd0);
    go_to(t1 + 130); check("dstop_stay", 32'(busy), 32'd0);
    check("dstop_duty", duty_cycle, 32'd0);

    // reset mid RAMP_UP at level 128
    pulse(1'b1, 1'b0, 1'b0, 4'b0011);
    t2 = cyc_cnt;
    go_to(t2 + 8); check("mr_lvl", duty_cycle, 32'h0000_8080);
    go_to(t2 + 9);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_en", 32'(en), 32'd0);
    check("mr_duty", duty_cycle, 32'd0);
    check("mr_done", 32'(cycle_done), 32'd0);
    cyc();
    pulse(1'b1, 1'b0, 1'b0, 4'b0001);
    t3 = cyc_cnt;
    go_to(t3 + 3); check("mr_re0", duty_cycle, 32'd0);
    go_to(t3 + 4); check("mr_re1", duty_cycle, 32'h0000_0040);
    cyc();

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
